// File: rtl/wb_cmd_master_pkg.sv
// Shared Wishbone definitions for the command master: FSM state
// encoding, default bus widths and the timeout-counter width.
package wb_cmd_master_pkg;

    localparam int wb_dat_width_def = 32;
    localparam int wb_adr_width_def = 32;
    localparam int tmo_cnt_width    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command/response handshake plus Wishbone master signals of wb_cmd_master.
// modport master : the wb_cmd_master side (drives cmd_ready, rsp_*, wb_* outputs)
// modport slave  : the environment side (command source, response sink, Wishbone slave)
interface wb_cmd_master_if
    import wb_cmd_master_pkg::*;
#(
    parameter int wb_dat_width = wb_dat_width_def,
    parameter int wb_adr_width = wb_adr_width_def
);
    logic                      cmd_valid_i;
    logic                      cmd_ready_o;
    logic                      cmd_we_i;
    logic [wb_adr_width-1:0]   cmd_adr_i;
    logic [wb_dat_width-1:0]   cmd_dat_i;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i;
    logic [wb_dat_width-1:0]   rsp_dat_o;
    logic                      rsp_err_o;
    logic [wb_adr_width-1:0]   wb_adr_o;
    logic [wb_dat_width-1:0]   wb_dat_o;
    logic                      wb_we_o;
    logic [wb_dat_width/8-1:0] wb_sel_o;
    logic                      wb_cyc_o;
    logic                      wb_stb_o;
    logic                      wb_ack_i;
    logic [wb_dat_width-1:0]   wb_dat_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, wb_ack_i, wb_dat_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
               wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, wb_ack_i, wb_dat_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
               wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o
    );
endinterface

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle timeout counter.
// clk, rst : clock, async active-high reset
// clr      : restart counting from zero
// en       : one sampling edge without ack
// expired  : the enabled edge in progress brings the count to 'limit'
module wb_timeout_cnt
    import wb_cmd_master_pkg::*;
#(
    parameter int limit = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [tmo_cnt_width-1:0] last_cnt = tmo_cnt_width'(limit - 1);

    logic [tmo_cnt_width-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Reported combinationally so the FSM can leave BUS on the very edge
    // whose increment reaches the limit.
    assign expired = en && (cnt_q == last_cnt);
endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master driven by a valid/ready command
// port and returning a valid/ready response (read data or timeout error).
// clk, rst : clock, async active-high reset
// bus      : wb_cmd_master_if.master (cmd_*, rsp_*, wb_* signals)
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// BUS     | cyc/stb asserted, waiting for ack or timeout
// RESP    | response held until rsp_ready
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int wb_dat_width   = wb_dat_width_def,
    parameter int wb_adr_width   = wb_adr_width_def,
    parameter int timeout_cycles = 16
) (
    input  logic            clk,
    input  logic            rst,
    wb_cmd_master_if.master bus
);
    wb_state_e               state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [wb_adr_width-1:0] adr_q, adr_d;
    logic [wb_dat_width-1:0] dat_q, dat_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [wb_dat_width-1:0] rsp_dat_q, rsp_dat_d;
    logic                    cnt_clr, cnt_en, cnt_expired;

    wb_timeout_cnt #(.limit(timeout_cycles)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (cnt_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // cmd_ready is implied here: the flops only update with rst low.
                if (bus.cmd_valid_i) begin
                    adr_d   = bus.cmd_adr_i;
                    dat_d   = bus.cmd_dat_i;
                    we_d    = bus.cmd_we_i;
                    cyc_d   = 1'b1;
                    cnt_clr = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack takes priority over a timeout landing on the same edge.
                if (bus.wb_ack_i) begin
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? '0 : bus.wb_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_expired) begin
                        cyc_d       = 1'b0;
                        rsp_dat_d   = '0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.cmd_ready_o = (state_q == ST_IDLE) && !rst;
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = cyc_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_sel_o    = rst ? '0 : '1;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master with an 8-bit GPIO slave at base 0
// (0x0 data out, 0x4 direction, 0x8 input pins tied low, 0xC unmapped).
module tb_wb_cmd_master;
    import wb_cmd_master_pkg::*;

    localparam int dw  = 32;
    localparam int aw  = 32;
    localparam int tmo = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_cmd_master_if #(.wb_dat_width(dw), .wb_adr_width(aw)) bus ();

    wb_cmd_master #(
        .wb_dat_width   (dw),
        .wb_adr_width   (aw),
        .timeout_cycles (tmo)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // GPIO slave: ack registered, inserted after slv_wait extra cycles
    logic [7:0]  gpio_out, gpio_dir;
    logic        slv_ack;
    logic        slv_off   = 1'b0;
    logic        stray_ack = 1'b0;
    int          slv_wait  = 0;
    int          slv_cnt;
    logic [31:0] slv_rdata;

    always_comb begin
        slv_rdata = 32'h0;
        case (bus.wb_adr_o[3:2])
            2'd0:    slv_rdata = {24'h0, gpio_out};
            2'd1:    slv_rdata = {24'h0, gpio_dir};
            default: slv_rdata = 32'h0;
        endcase
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            slv_ack  <= 1'b0;
            slv_cnt  <= 0;
            gpio_out <= 8'h0;
            gpio_dir <= 8'h0;
        end else begin
            slv_ack <= 1'b0;
            if (bus.wb_cyc_o && bus.wb_stb_o && !slv_ack && !slv_off) begin
                if (slv_cnt >= slv_wait) begin
                    slv_ack <= 1'b1;
                    slv_cnt <= 0;
                end else begin
                    slv_cnt <= slv_cnt + 1;
                end
            end else begin
                slv_cnt <= 0;
            end
            if (slv_ack && bus.wb_cyc_o && bus.wb_stb_o && bus.wb_we_o) begin
                if (bus.wb_adr_o[3:2] == 2'd0) gpio_out <= bus.wb_dat_o[7:0];
                if (bus.wb_adr_o[3:2] == 2'd1) gpio_dir <= bus.wb_dat_o[7:0];
            end
        end
    end

    assign bus.wb_ack_i = slv_ack | stray_ack;
    assign bus.wb_dat_i = slv_ack ? slv_rdata : 32'hDEAD_BEEF;

    // Reference model: register contents plus timing rule. A registered
    // slave with w wait cycles acks on the (w+2)-th BUS edge; the master
    // gives up on edge tmo unless ack arrives on or before it.
    logic [7:0] m_out, m_dir;

    task automatic model_reset();
        m_out = 8'h0;
        m_dir = 8'h0;
    endtask

    task automatic model_exec(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                              input int wait_c, input bit off,
                              output logic [31:0] exp_dat, output bit exp_err, output int exp_len);
        exp_err = off || (wait_c + 2 > tmo);
        exp_len = exp_err ? tmo : wait_c + 2;
        exp_dat = 32'h0;
        if (!exp_err) begin
            if (we) begin
                if (adr[3:2] == 2'd0) m_out = dat[7:0];
                if (adr[3:2] == 2'd1) m_dir = dat[7:0];
            end else begin
                if (adr[3:2] == 2'd0) exp_dat = {24'h0, m_out};
                if (adr[3:2] == 2'd1) exp_dat = {24'h0, m_dir};
            end
        end
    endtask

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_cmd(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                          input int wait_c, input bit off, input int rdy_dly);
        logic [31:0] exp_dat;
        bit          exp_err;
        int          exp_len;
        int          guard;
        int          n;
        bit          bus_ok;
        bit          hold_ok;
        slv_wait = wait_c;
        slv_off  = off;
        model_exec(we, adr, dat, wait_c, off, exp_dat, exp_err, exp_len);
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        guard = 0;
        while (!bus.cmd_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_accept_timeout", 64'(guard < 50), 64'd1);
        @(posedge clk);
        #1;
        check("e0_bus", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.cmd_ready_o, bus.wb_sel_o}),
              64'({1'b1, 1'b1, we, 1'b0, 4'hF}));
        check("e0_adr_dat", {bus.wb_adr_o, bus.wb_dat_o}, {adr, dat});
        // cmd inputs change during BUS/RESP and must be ignored
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = ~we;
        bus.cmd_adr_i   = $urandom;
        bus.cmd_dat_i   = $urandom;
        n      = 0;
        bus_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.rsp_valid_o)
                bus_ok &= bus.wb_cyc_o && bus.wb_stb_o && !bus.cmd_ready_o && (bus.wb_we_o == we) &&
                          (bus.wb_adr_o == adr) && (bus.wb_dat_o == dat);
        end while (!bus.rsp_valid_o && n < 40);
        check("bus_stable", 64'(bus_ok), 64'd1);
        check("rsp_latency", 64'(n), 64'(exp_len));
        check("rsp_fields", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_err_o, bus.rsp_dat_o}),
              64'({1'b0, 1'b0, exp_err, exp_dat}));
        stray_ack = 1'b1;
        hold_ok   = 1'b1;
        for (int i = 0; i < rdy_dly; i++) begin
            @(posedge clk);
            #1;
            hold_ok &= (bus.rsp_valid_o == 1'b1) && (bus.rsp_err_o == exp_err) && (bus.rsp_dat_o == exp_dat) &&
                       !bus.cmd_ready_o && !bus.wb_cyc_o;
        end
        check("rsp_hold", 64'(hold_ok), 64'd1);
        stray_ack       = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b0;
        check("consume", 64'({bus.rsp_valid_o, bus.wb_cyc_o, bus.cmd_ready_o}), 64'b001);
        bus.cmd_valid_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_valid;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_adr_i   = 32'h0;
        bus.cmd_dat_i   = 32'h0;
        bus.rsp_ready_i = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({bus.cmd_ready_o, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
                                 bus.rsp_valid_o, bus.rsp_err_o, bus.wb_sel_o}), 64'd0);
        check("reset_data", {bus.wb_adr_o, bus.wb_dat_o}, 64'd0);
        check("reset_rsp_dat", 64'(bus.rsp_dat_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_ready", 64'({bus.cmd_ready_o, bus.wb_sel_o}), 64'h1F);

        // stray ack in IDLE must not start anything
        stray_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        stray_ack = 1'b0;
        check("idle_stray_ack", 64'({bus.wb_cyc_o, bus.rsp_valid_o, bus.cmd_ready_o}), 64'b001);

        do_cmd(1'b1, 32'h4, 32'h0000_00FF, 0, 1'b0, 1);
        check("gpio_dir", 64'(gpio_dir), 64'hFF);
        do_cmd(1'b1, 32'h0, 32'h0000_005A, 0, 1'b0, 0);
        do_cmd(1'b0, 32'h0, 32'h0, 0, 1'b0, 0);
        do_cmd(1'b0, 32'h8, 32'h0, 0, 1'b0, 0);
        do_cmd(1'b0, 32'h4, 32'h0, 3, 1'b1, 0);
        do_cmd(1'b1, 32'h0, 32'h0000_00C3, 0, 1'b0, 5);
        do_cmd(1'b0, 32'h0, 32'h0, tmo - 2, 1'b0, 0);
        do_cmd(1'b1, 32'h0, 32'h0000_0077, tmo - 1, 1'b0, 2);
        do_cmd(1'b0, 32'h0, 32'h0, 1, 1'b0, 1);

        // reset in the middle of BUS
        slv_off = 1'b1;
        @(negedge clk);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = 1'b1;
        bus.cmd_adr_i   = 32'h0;
        bus.cmd_dat_i   = 32'h33;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        check("rst_bus_started", 64'(bus.wb_cyc_o), 64'd1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_bus_drop", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o, bus.cmd_ready_o}), 64'd0);
        model_reset();
        @(negedge clk);
        rst     = 1'b0;
        slv_off = 1'b0;
        n_valid = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid_o || bus.wb_cyc_o) n_valid++;
        end
        check("rst_no_rsp", 64'(n_valid), 64'd0);
        do_cmd(1'b1, 32'h0, 32'h0000_0011, 0, 1'b0, 0);
        do_cmd(1'b0, 32'h0, 32'h0, 2, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            bit          r_we;
            logic [31:0] r_adr;
            int          r_wait;
            bit          r_off;
            r_we   = 1'($urandom_range(0, 1));
            r_adr  = 32'($urandom_range(0, 3)) << 2;
            r_off  = ($urandom_range(0, 9) == 0);
            r_wait = ($urandom_range(0, 3) == 0) ? $urandom_range(tmo - 3, tmo + 1) : $urandom_range(0, 5);
            do_cmd(r_we, r_adr, $urandom, r_wait, r_off, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
